// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and the serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output sum, cout, busy, done
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder cells and an OR.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s1;
    logic c1;
    logic c2;

    halfadd u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s1),
        .c_o (c1)
    );

    halfadd u_ha1 (
        .a_i (s1),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c2)
    );

    assign c_o = c1 | c2;
endmodule

// File: rtl/halfadd.sv
// Half-adder cell used as a building block for the full adder.
module halfadd (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock; WIDTH+2 cycles per result.
// Define SERIAL_ADDER_SUB_EN to add the A-B mode (sub port on the interface).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             sub_q;
    logic             sub_in;
    logic             b_bit;
    logic             fa_s;
    logic             fa_c;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    // Subtract is A + ~B + 1: invert B bits here, carry-in seeded with sub.
    assign b_bit = b_q[0] ^ sub_q;
    assign last  = (cnt_q == CW'(WIDTH - 1));

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_bit),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= sub_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= sub_in;
`endif
                    end
                end
                SHIFT: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = carry_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic s,
                          input logic [7:0] es, input logic ec);
        bus8.a = a;
        bus8.b = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = s;
`endif
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check({tag, ".busy1"}, 64'(bus8.busy), 64'd1);
        repeat (7) tick();
        check({tag, ".busy8"}, 64'(bus8.busy), 64'd1);
        check({tag, ".nodone8"}, 64'(bus8.done), 64'd0);
        tick();
        check({tag, ".done"}, 64'(bus8.done), 64'd1);
        check({tag, ".busy_lo"}, 64'(bus8.busy), 64'd0);
        check({tag, ".sum"}, 64'(bus8.sum), 64'(es));
        check({tag, ".cout"}, 64'(bus8.cout), 64'(ec));
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = 1'b0;
        bus1.sub   = 1'b0;
`endif
        #12;
        check("rst.sum", 64'(bus8.sum), 64'd0);
        check("rst.cout", 64'(bus8.cout), 64'd0);
        check("rst.busy", 64'(bus8.busy), 64'd0);
        check("rst.done", 64'(bus8.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // A5 + 5A: busy in cycles 1..8, done only in cycle 9
        bus8.a     = 8'hA5;
        bus8.b     = 8'h5A;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("a5.busy_c%0d", c), 64'(bus8.busy), 64'd1);
            check($sformatf("a5.done_c%0d", c), 64'(bus8.done), 64'd0);
            if (c < 8) tick();
        end
        tick();
        check("a5.done", 64'(bus8.done), 64'd1);
        check("a5.busy", 64'(bus8.busy), 64'd0);
        check("a5.sum", 64'(bus8.sum), 64'hFF);
        check("a5.cout", 64'(bus8.cout), 64'd0);
        tick();
        check("a5.pulse", 64'(bus8.done), 64'd0);
        check("a5.hold", 64'(bus8.sum), 64'hFF);

        // Overflow, then back-to-back from the IDLE cycle after DONE
        run_op("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        check("b2b.hold_sum", 64'(bus8.sum), 64'h00);
        check("b2b.hold_cout", 64'(bus8.cout), 64'd1);
        run_op("b2b", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        tick();

        // start held high: operands changed mid-op must be ignored
        bus8.a     = 8'h01;
        bus8.b     = 8'h02;
        bus8.start = 1'b1;
        tick();
        check("held.busy1", 64'(bus8.busy), 64'd1);
        bus8.a = 8'h40;
        bus8.b = 8'h08;
        repeat (7) tick();
        check("held.busy8", 64'(bus8.busy), 64'd1);
        tick();
        check("held.done1", 64'(bus8.done), 64'd1);
        check("held.sum1", 64'(bus8.sum), 64'h03);
        tick();
        check("held.idle_busy", 64'(bus8.busy), 64'd0);
        check("held.idle_done", 64'(bus8.done), 64'd0);
        check("held.idle_sum", 64'(bus8.sum), 64'h03);
        tick();
        check("held.accept", 64'(bus8.busy), 64'd1);
        bus8.start = 1'b0;
        repeat (8) tick();
        check("held.done2", 64'(bus8.done), 64'd1);
        check("held.sum2", 64'(bus8.sum), 64'h48);
        check("held.cout2", 64'(bus8.cout), 64'd0);
        tick();

        // Reset in SHIFT cycle 4 aborts without a done pulse
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        check("abort.busy", 64'(bus8.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.sum", 64'(bus8.sum), 64'd0);
        check("abort.cout", 64'(bus8.cout), 64'd0);
        check("abort.busy0", 64'(bus8.busy), 64'd0);
        check("abort.done", 64'(bus8.done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("abort.nodone%0d", c), 64'(bus8.done), 64'd0);
        end
        run_op("post", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub57", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        tick();
        run_op("sub75", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        tick();
        bus8.sub = 1'b0;
`endif

        // WIDTH=1: 1+1 -> sum 0, cout 1, done in cycle 2
        bus1.a     = 1'b1;
        bus1.b     = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("w1.busy", 64'(bus1.busy), 64'd1);
        check("w1.nodone", 64'(bus1.done), 64'd0);
        tick();
        check("w1.done", 64'(bus1.done), 64'd1);
        check("w1.busy0", 64'(bus1.busy), 64'd0);
        check("w1.sum", 64'(bus1.sum), 64'd0);
        check("w1.cout", 64'(bus1.cout), 64'd1);
        tick();
        check("w1.pulse", 64'(bus1.done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result bit width (legal range 1..64).
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL provide port: a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 SHALL provide port: b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 SHALL provide port: sub  input  1  0 = A+B, 1 = A-B; captured with operands; present only with SERIAL_ADDER_SUB_EN.
REQ-008 SHALL provide port: sum  output  WIDTH  result, valid from done onward.
REQ-009 SHALL provide port: cout  output  1  final carry-out (for subtract: 1 = no borrow).
REQ-010 SHALL provide port: busy  output  1  high while the operation is in progress (SHIFT state).
REQ-011 SHALL provide port: done  output  1  one-cycle pulse when sum/cout become valid.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at edge k SHALL capture a, b (and sub), set carry = sub (0 without macro), clear bit counter, and go to SHIFT.
REQ-014 SHIFT SHALL add one bit per edge, LSB first: the full-adder sum bit shifts into the sum register MSB, the carry register updates, and the operand registers shift right.
REQ-015 SHALL use ~b bits in place of b bits when the captured sub=1.
REQ-016 After exactly WIDTH SHIFT edges, the FSM SHALL go to DONE; done SHALL be high for the one cycle after edge k+WIDTH, and busy SHALL be low in that cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; a start high in DONE is ignored.
REQ-018 start while busy SHALL be ignored, with no effect on operands, counter or outputs.
REQ-019 sum and cout SHALL hold their last result from DONE until the next accepted start; during SHIFT, sum shows partial contents and is not valid.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL equal bit WIDTH of A + B' + carry_in.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within an operation.
REQ-022 Back-to-back operation SHALL be supported: start in the IDLE cycle right after DONE gives a throughput of one result per WIDTH+2 cycles.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE; sum=0, cout=0, busy=0, done=0; operand, carry and counter registers = 0.
REQ-024 Reset during SHIFT SHALL abort the operation with no done pulse; after reset is released, the first start SHALL be accepted normally.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN defined: the sub port and subtract mode SHALL exist as specified.
REQ-026 Macro SERIAL_ADDER_SUB_EN undefined: the sub port SHALL be absent, carry-in SHALL always be 0, and the block SHALL be add-only.

Structure
REQ-027 The shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH.
REQ-028 The single sub-module full_adder SHALL be built from two existing halfadd cells plus an OR for carry, and SHALL be instantiated once for the bit-serial datapath.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- WIDTH=8, a=0xA5, b=0x5A, start at edge 0 -> done at cycle 9, sum=0xFF, cout=0, busy high for cycles 1..8.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1; then back-to-back start with a=0x10, b=0x20 -> sum=0x30, cout=0.
- WIDTH=8, start held high throughout -> second operation accepted only in the IDLE cycle after done; no start taken during SHIFT.
- WIDTH=8, rst_n low at SHIFT cycle 4 -> all outputs 0 at once, no done pulse; next operation 0x03+0x04 -> sum=0x07.
- SERIAL_ADDER_SUB_EN, WIDTH=8: 0x05-0x07 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1.
- WIDTH=1: 1+1 -> sum=0, cout=1, done at cycle 2.
